// File: rtl/ibex_regfile_fpga_pkg.sv
// Shared types and helpers for the FPGA register file: clear/ready FSM states
// and the word count derived from the RV32E selection.
package ibex_regfile_fpga_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_register_file_fpga_rport.sv
// One asynchronous read port: word select, masking of x0, out-of-range and
// not-yet-cleared reads, and optional forwarding of the write in flight.
module ibex_register_file_fpga_rport
  import ibex_regfile_fpga_pkg::*;
#(
  parameter int unsigned           DataWidth   = 32,
  parameter int unsigned           NumWords    = 32,
  parameter int unsigned           IdxW        = 5,
  parameter bit                    BypassEn    = 1'b0,
  parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
  input  logic [4:0]           raddr,
  input  logic [DataWidth-1:0] mem [NumWords],
  input  logic                 ready,
  input  logic                 wr_commit,
  input  logic [4:0]           waddr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  logic in_range;
  logic bypass_hit;

  // Only the 16-word configuration has addresses outside the array.
  assign in_range   = (NumWords == 32'd16) ? ~raddr[4] : 1'b1;
  assign bypass_hit = BypassEn && wr_commit && (waddr == raddr);

  always_comb begin
    rdata = mem[raddr[IdxW-1:0]];
    if (!ready || (raddr == 5'd0) || !in_range) begin
      rdata = WordZeroVal;
    end else if (bypass_hit) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/ibex_register_file_fpga_mp.sv
// Multi-read-port register file for FPGA: unreset distributed-RAM storage,
// cleared by a post-reset sweep, with a combinational write-error alert.
//
//   state    | meaning
//   RF_CLEAR | sweeping WordZeroVal into word[cnt_q]; reads masked, writes dropped
//   RF_READY | normal operation; writes to legal nonzero addresses accepted
module ibex_register_file_fpga_mp
  import ibex_regfile_fpga_pkg::*;
#(
  parameter bit                    RV32E        = 1'b0,
  parameter int unsigned           DataWidth    = 32,
  parameter int unsigned           NumReadPorts = 2,
  parameter bit                    BypassEn     = 1'b0,
  parameter bit                    WrenCheck    = 1'b0,
  parameter logic [DataWidth-1:0]  WordZeroVal  = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [4:0]                        waddr_a_i,
  input  logic [DataWidth-1:0]              wdata_a_i,
  input  logic                              we_a_i,
  output logic                              init_done_o,
  output logic                              err_o
);

  localparam int unsigned NumWords = num_words(RV32E);
  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam logic [4:0]  LastIdx  = 5'(NumWords - 1);

  if ((NumReadPorts < 1) || (NumReadPorts > 4)) begin : g_bad_read_ports
    $error("NumReadPorts must be within 1..4");
  end

  rf_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  // Storage carries no reset so it maps onto LUT RAM; the sweep defines it.
  logic [DataWidth-1:0] mem [NumWords] = '{default: WordZeroVal};

  logic                 ready;
  logic                 addr_legal;
  logic [NumWords-1:0]  we_dec;
  logic                 wr_commit;
  logic                 wr_en;
  logic [IdxW-1:0]      wr_idx;
  logic [DataWidth-1:0] wr_data;
  logic                 drop_err;
  logic                 wren_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIdx) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready       = (state_q == RF_READY);
  assign init_done_o = ready;
  assign addr_legal  = RV32E ? ~waddr_a_i[4] : 1'b1;

  always_comb begin
    we_dec = '0;
    if (we_a_i && ready && addr_legal && (waddr_a_i != 5'd0)) begin
      we_dec[waddr_a_i[IdxW-1:0]] = 1'b1;
    end
  end

  assign wr_commit = |we_dec;

  // Single write port shared between the clear sweep and normal writes.
  assign wr_en   = !ready || wr_commit;
  assign wr_idx  = ready ? waddr_a_i[IdxW-1:0] : cnt_q[IdxW-1:0];
  assign wr_data = ready ? wdata_a_i : WordZeroVal;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign drop_err = we_a_i && (!ready || !addr_legal);
  assign wren_err = WrenCheck && (!$onehot0(we_dec) || (!we_a_i && wr_commit));
  assign err_o    = drop_err || wren_err;

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rport
    ibex_register_file_fpga_rport #(
      .DataWidth  (DataWidth),
      .NumWords   (NumWords),
      .IdxW       (IdxW),
      .BypassEn   (BypassEn),
      .WordZeroVal(WordZeroVal)
    ) u_rport (
      .raddr    (raddr_i[5*p +: 5]),
      .mem      (mem),
      .ready    (ready),
      .wr_commit(wr_commit),
      .waddr    (waddr_a_i),
      .wdata    (wdata_a_i),
      .rdata    (rdata_o[DataWidth*p +: DataWidth])
    );
  end

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
// Bench for two register file configurations driven by shared write traffic:
// A = 32 words, 3 ports, forwarding on; B = 16 words, 2 ports, no forwarding.
module tb_ibex_register_file_fpga_mp;

  localparam logic [31:0] WZV_A = 32'h0000_0000;
  localparam logic [31:0] WZV_B = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] raddr_a = '0;
  logic [95:0] rdata_a;
  logic [9:0]  raddr_b = '0;
  logic [63:0] rdata_b;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        done_a, done_b, err_a, err_b;

  always #5 clk = ~clk;

  ibex_register_file_fpga_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(3),
    .BypassEn(1'b1), .WrenCheck(1'b1), .WordZeroVal(WZV_A)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_a), .rdata_o(rdata_a),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .init_done_o(done_a), .err_o(err_a)
  );

  ibex_register_file_fpga_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2),
    .BypassEn(1'b0), .WrenCheck(1'b0), .WordZeroVal(WZV_B)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_b), .rdata_o(rdata_b),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .init_done_o(done_b), .err_o(err_b)
  );

  // Reference model: architectural contents plus edges seen since reset release.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int cyc = 0;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic string kind_name(input int kind);
    case (kind)
      0: return "rdata_a";
      1: return "rdata_b";
      2: return "err_a";
      3: return "err_b";
      4: return "init_done_a";
      default: return "init_done_b";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      0: return rdata_a[idx*32 +: 32];
      1: return rdata_b[idx*32 +: 32];
      2: return {31'b0, err_a};
      3: return {31'b0, err_b};
      4: return {31'b0, done_a};
      default: return {31'b0, done_b};
    endcase
  endfunction

  task automatic push(input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: outputs are combinational, so everything queued for the current
  // cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = actual(e.kind, e.idx);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d] cyc=%0d: got %h expected %h",
                 kind_name(e.kind), e.idx, cyc, act, e.exp);
      end
    end
  end

  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] b0, input logic [4:0] b1);
    logic [4:0] aa [3];
    logic [4:0] bb [2];
    logic ra, rb, acc_a, acc_b;
    logic [31:0] exp;
    we = w; waddr = wa; wdata = wd;
    raddr_a = {a2, a1, a0};
    raddr_b = {b1, b0};
    aa = '{a0, a1, a2};
    bb = '{b0, b1};
    ra = (cyc >= 32);
    rb = (cyc >= 16);
    acc_a = w && ra && (wa != 5'd0);
    acc_b = w && rb && (wa != 5'd0) && (wa < 5'd16);
    push(4, 0, {31'b0, ra});
    push(5, 0, {31'b0, rb});
    push(2, 0, {31'b0, w && !ra});
    push(3, 0, {31'b0, w && (!rb || (wa >= 5'd16))});
    for (int p = 0; p < 3; p++) begin
      if (!ra || aa[p] == 5'd0) exp = WZV_A;
      else if (acc_a && wa == aa[p]) exp = wd;
      else exp = ma[aa[p]];
      push(0, p, exp);
    end
    for (int p = 0; p < 2; p++) begin
      if (!rb || bb[p] == 5'd0 || bb[p] >= 5'd16) exp = WZV_B;
      else exp = mb[bb[p]];
      push(1, p, exp);
    end
    @(posedge clk);
    if (acc_a) ma[wa] = wd;
    if (acc_b) mb[wa] = wd;
    cyc++;
    #1;
  endtask

  task automatic rand_step(input bit allow_we);
    logic w;
    w = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
    step(w, 5'($urandom_range(0, 31)), $urandom,
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  // Asserts reset (possibly mid-cycle), checks the held-in-reset outputs,
  // then releases it and lets the first sweep edge pass.
  task automatic do_reset();
    we = 1'b0;
    rst_n = 1'b0;
    #1;
    push(4, 0, 32'd0);
    push(5, 0, 32'd0);
    push(2, 0, 32'd0);
    push(3, 0, 32'd0);
    for (int p = 0; p < 3; p++) push(0, p, WZV_A);
    for (int p = 0; p < 2; p++) push(1, p, WZV_B);
    @(negedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      ma[i] = WZV_A;
      mb[i] = WZV_B;
    end
    cyc = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Sweep with a dropped write to x3 on sweep cycle 10.
    while (cyc < 40) begin
      if (cyc == 10) step(1'b1, 5'd3, 32'hCAFE_0003, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3);
      else rand_step(1'b0);
    end

    for (int a = 1; a < 32; a++) begin
      step(1'b0, 5'd0, 32'd0, 5'(a), 5'(a), 5'(a), 5'(a), 5'(a));
    end

    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd1, 5'd2, 5'd0, 5'd1);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    step(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd7, 5'd7, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7);

    step(1'b1, 5'd20, 32'h0BAD_C0DE, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20);
    step(1'b0, 5'd0, 32'd0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20);
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    repeat (300) rand_step(1'b1);

    // Reset mid-operation, then again mid-sweep at sweep cycle 20.
    do_reset();
    while (cyc < 20) rand_step(1'b1);
    do_reset();
    while (cyc < 45) rand_step(1'b1);
    for (int a = 1; a < 32; a++) begin
      step(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 5'(a), 5'(a), 5'(31 - a));
    end
    repeat (100) rand_step(1'b1);

    we = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ibex_register_file_fpga_mp.md
IBEX_REGISTER_FILE_FPGA_MP -- requirements
Module: ibex_register_file_fpga_mp

Interface
REQ-001 The block SHALL have parameter RV32E, default 0, which selects 16 words when 1 and 32 words when 0.
REQ-002 The block SHALL have parameter DataWidth, default 32, giving the word width.
REQ-003 The block SHALL have parameter NumReadPorts, default 2, legal range 1..4.
REQ-004 The block SHALL have parameter BypassEn, default 0, which enables same-cycle write-to-read forwarding when 1.
REQ-005 The block SHALL have parameter WrenCheck, default 0, which enables spurious-write detection when 1.
REQ-006 The block SHALL have parameter WordZeroVal, DataWidth bits, default '0, used as the x0 value and the clear value.
REQ-007 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port raddr_i, input, NumReadPorts*5 bits: read addresses, with port p in bits [5p+4:5p].
REQ-010 The block SHALL have port rdata_o, output, NumReadPorts*DataWidth bits: read data, with port p in slice p.
REQ-011 The block SHALL have port waddr_a_i, input, 5 bits: write address.
REQ-012 The block SHALL have port wdata_a_i, input, DataWidth bits: write data.
REQ-013 The block SHALL have port we_a_i, input, 1 bit: write enable.
REQ-014 The block SHALL have port init_done_o, output, 1 bit: high once the post-reset clear sweep has completed.
REQ-015 The block SHALL have port err_o, output, 1 bit: combinational alert for a dropped or spurious write.

Function
REQ-016 Reads SHALL be asynchronous (zero-cycle latency), and all ports SHALL be independent.
REQ-017 Address 0 SHALL always read WordZeroVal, and writes to address 0 SHALL be ignored.
REQ-018 With RV32E=1, addresses 16..31 SHALL read WordZeroVal, and writes to them SHALL be dropped and assert err_o.
REQ-019 Writes SHALL be synchronous on the rising edge of clk_i when we_a_i=1, init_done_o=1 and the address is legal.
REQ-020 With BypassEn=1, a read of a legal nonzero address that equals waddr_a_i while a write is accepted SHALL return wdata_a_i in the same cycle.
REQ-021 With BypassEn=0, that same read SHALL return the old value.
REQ-022 The FSM SHALL have states CLEAR and READY; reset SHALL enter CLEAR with the sweep counter at 0.
REQ-023 In CLEAR, each cycle SHALL write WordZeroVal to word[counter] and then increment the counter.
REQ-024 The counter reaching NumWords-1 SHALL cause a transition to READY on the next edge; the sweep therefore takes exactly NumWords cycles.
REQ-025 init_done_o SHALL be 1 only in READY.
REQ-026 In CLEAR, all rdata_o SHALL return WordZeroVal regardless of address.
REQ-027 A we_a_i asserted in CLEAR SHALL be dropped and SHALL assert err_o in that cycle.
REQ-028 With WrenCheck=1, err_o SHALL also assert when the decoded one-hot write-enable vector is not one-hot-or-zero, or when it is nonzero while we_a_i=0.
REQ-029 err_o SHALL have no registered state and SHALL be 0 when no error condition is present.
REQ-030 Assertion of rst_ni mid-sweep or mid-operation SHALL immediately return the FSM to CLEAR and the counter to 0, and the sweep SHALL restart from word 0.

Reset
REQ-031 Asynchronous reset values SHALL be: state=CLEAR, counter=0, init_done_o=0.
REQ-032 The storage array SHALL NOT be reset; its content SHALL be defined only by the sweep, so that it stays inferable as distributed RAM.
REQ-033 The storage SHALL additionally carry an initial value of WordZeroVal for simulation and bitstream.

Structure
REQ-034 Package ibex_regfile_fpga_pkg SHALL hold the FSM state enum (RF_CLEAR, RF_READY) and the function deriving NumWords from RV32E.
REQ-035 One sub-module, ibex_register_file_fpga_rport, SHALL implement one read port (address mux, x0/illegal/clear masking, bypass) and SHALL be instantiated NumReadPorts times via generate.
REQ-036 Elaboration SHALL fail for NumReadPorts outside 1..4.

Verification
REQ-037 Release reset with RV32E=0 -> init_done_o SHALL be 0 for exactly 32 cycles and then 1, and all 31 nonzero addresses SHALL read WordZeroVal.
REQ-038 In READY, write 0xDEADBEEF to x5, then read x5 on all ports the next cycle -> each SHALL return 0xDEADBEEF; reading x0 SHALL return WordZeroVal.
REQ-039 BypassEn=1, write 0x12345678 to x7 while port 1 reads x7 -> port 1 SHALL return 0x12345678 in the same cycle; with BypassEn=0 it SHALL return the old value.
REQ-040 Assert we_a_i to x3 during cycle 10 of the sweep -> err_o SHALL be 1 that cycle, and x3 SHALL read WordZeroVal after READY.
REQ-041 RV32E=1, write to x20 -> err_o SHALL be 1 and x20 SHALL read WordZeroVal; the sweep SHALL last 16 cycles.
REQ-042 Assert rst_ni low at sweep cycle 20 and release it -> the counter SHALL restart at 0, and init_done_o SHALL rise 32 cycles after release.
